// File: rtl/ladybird_config.sv
// Shared configuration for the ladybird core: datapath and address width.
package ladybird_config;

  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/ladybird_bus_arbiter.sv
// Two-requester round-robin arbiter onto one memory port; one transaction in flight.
// Grants and the response path are combinational decodes of the registered FSM.
module ladybird_bus_arbiter #(
  parameter int unsigned XLEN = ladybird_config::XLEN
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              m0_req,
  input  logic [XLEN-1:0]   m0_addr,
  input  logic [XLEN-1:0]   m0_wdata,
  input  logic [XLEN/8-1:0] m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_data_gnt,
  output logic [XLEN-1:0]   m0_rdata,
  input  logic              m1_req,
  input  logic [XLEN-1:0]   m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  input  logic [XLEN/8-1:0] m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_data_gnt,
  output logic [XLEN-1:0]   m1_rdata,
  output logic              s_req,
  output logic [XLEN-1:0]   s_addr,
  output logic [XLEN-1:0]   s_wdata,
  output logic [XLEN/8-1:0] s_wstrb,
  input  logic              s_gnt,
  input  logic              s_data_gnt,
  input  logic [XLEN-1:0]   s_rdata
);

  localparam int unsigned SW = XLEN / 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_owner;
  logic            r_prio;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [SW-1:0]   r_wstrb;

  logic            w_any_req;
  logic            w_sel;
  logic            w_grant;
  logic            w_issue;
  logic            w_rsp;

  // r_prio names the requester that wins a tie; it points away from the last one served.
  assign w_any_req = m0_req | m1_req;
  assign w_sel     = (m0_req & m1_req) ? r_prio : m1_req;
  assign w_grant   = (r_state == ST_IDLE) & w_any_req & ~arst;
  assign w_issue   = (r_state == ST_ISSUE);
  assign w_rsp     = (r_state == ST_WAIT_RSP) & s_data_gnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_any_req)  w_state_nxt = ST_ISSUE;
      ST_ISSUE:    if (s_gnt)      w_state_nxt = ST_WAIT_RSP;
      ST_WAIT_RSP: if (s_data_gnt) w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the winner's request; fields hold until the next grant.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_grant) begin
      r_owner <= w_sel;
      r_addr  <= w_sel ? m1_addr  : m0_addr;
      r_wdata <= w_sel ? m1_wdata : m0_wdata;
      r_wstrb <= w_sel ? m1_wstrb : m0_wstrb;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_prio <= 1'b0;
    end else if (w_rsp) begin
      r_prio <= ~r_owner;
    end
  end

  assign m0_gnt      = w_grant & ~w_sel;
  assign m1_gnt      = w_grant &  w_sel;

  assign s_req       = w_issue;
  assign s_addr      = w_issue ? r_addr  : '0;
  assign s_wdata     = w_issue ? r_wdata : '0;
  assign s_wstrb     = w_issue ? r_wstrb : '0;

  assign m0_data_gnt = w_rsp & ~r_owner;
  assign m1_data_gnt = w_rsp &  r_owner;
  assign m0_rdata    = m0_data_gnt ? s_rdata : '0;
  assign m1_rdata    = m1_data_gnt ? s_rdata : '0;

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for ladybird_bus_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge of the same cycle.
module tb_ladybird_bus_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            arst;
  logic            m0_req, m1_req;
  logic [XLEN-1:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]      m0_wstrb, m1_wstrb;
  logic            m0_gnt, m1_gnt, m0_data_gnt, m1_data_gnt;
  logic [XLEN-1:0] m0_rdata, m1_rdata;
  logic            s_req, s_gnt, s_data_gnt;
  logic [XLEN-1:0] s_addr, s_wdata, s_rdata;
  logic [3:0]      s_wstrb;

  int checks = 0;
  int failures = 0;

  ladybird_bus_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .arst(arst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(m0_gnt), .m0_data_gnt(m0_data_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_data_gnt(m1_data_gnt), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_gnt(s_gnt), .s_data_gnt(s_data_gnt), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_sreq"},  32'(s_req), 32'd0);
    chk({tag, "_saddr"}, s_addr, 32'd0);
    chk({tag, "_dg0"},   32'(m0_data_gnt), 32'd0);
    chk({tag, "_dg1"},   32'(m1_data_gnt), 32'd0);
    chk({tag, "_rd0"},   m0_rdata, 32'd0);
    chk({tag, "_rd1"},   m1_rdata, 32'd0);
  endtask

  initial begin
    arst = 1'b1;
    m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_wstrb = 0; m1_wstrb = 0; s_gnt = 0; s_data_gnt = 0; s_rdata = 0;

    // Reset state
    @(negedge clk);
    chk_idle_outs("rst");
    chk("rst_g0", 32'(m0_gnt), 32'd0);
    chk("rst_g1", 32'(m1_gnt), 32'd0);
    nxt();
    arst = 1'b0;

    // Single read from m0 at minimum latency
    m0_req = 1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    @(negedge clk);
    chk("rd_g0", 32'(m0_gnt), 32'd1);
    chk("rd_g1", 32'(m1_gnt), 32'd0);
    chk("rd_c0_sreq", 32'(s_req), 32'd0);
    nxt();
    m0_req = 0; m0_addr = 32'hFFFF_FFFF; s_gnt = 1;
    @(negedge clk);
    chk("rd_c1_sreq", 32'(s_req), 32'd1);
    chk("rd_c1_saddr", s_addr, 32'h100);
    chk("rd_c1_sstrb", 32'(s_wstrb), 32'd0);
    chk("rd_c1_g0", 32'(m0_gnt), 32'd0);
    nxt();
    s_gnt = 0; s_data_gnt = 1; s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_c2_dg0", 32'(m0_data_gnt), 32'd1);
    chk("rd_c2_rd0", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_c2_dg1", 32'(m1_data_gnt), 32'd0);
    chk("rd_c2_rd1", m1_rdata, 32'd0);
    chk("rd_c2_sreq", 32'(s_req), 32'd0);
    nxt();
    s_data_gnt = 0;
    @(negedge clk);
    chk_idle_outs("rd_c3");
    nxt();

    // Round-robin from a fresh reset: both held high, memory always ready (3-cycle period)
    arst = 1;
    nxt();
    arst = 0;
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    s_gnt = 1; s_data_gnt = 1; s_rdata = 32'h55;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_g0", k), 32'(m0_gnt), 32'(k % 6 == 0));
      chk($sformatf("rr%0d_g1", k), 32'(m1_gnt), 32'(k % 6 == 3));
      chk($sformatf("rr%0d_dg0", k), 32'(m0_data_gnt), 32'(k % 6 == 2));
      chk($sformatf("rr%0d_dg1", k), 32'(m1_data_gnt), 32'(k % 6 == 5));
      nxt();
    end
    m0_req = 0; m1_req = 0; s_gnt = 0; s_data_gnt = 0; s_rdata = 0;

    // m1 write with s_gnt held off for three cycles
    m1_req = 1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0001;
    @(negedge clk);
    chk("wr_g1", 32'(m1_gnt), 32'd1);
    chk("wr_g0", 32'(m0_gnt), 32'd0);
    nxt();
    m1_req = 0; m1_addr = 32'hAAAA_AAAA; m1_wdata = 32'h0; m1_wstrb = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      s_gnt = (c == 4);
      @(negedge clk);
      chk($sformatf("wr%0d_sreq", c), 32'(s_req), 32'd1);
      chk($sformatf("wr%0d_saddr", c), s_addr, 32'h20);
      chk($sformatf("wr%0d_swd", c), s_wdata, 32'h1234_5678);
      chk($sformatf("wr%0d_sstrb", c), 32'(s_wstrb), 32'd1);
      chk($sformatf("wr%0d_dg1", c), 32'(m1_data_gnt), 32'd0);
      nxt();
    end
    s_gnt = 0; s_data_gnt = 1; s_rdata = 32'h0BAD_0001;
    @(negedge clk);
    chk("wr_dg1", 32'(m1_data_gnt), 32'd1);
    chk("wr_rd1", m1_rdata, 32'h0BAD_0001);
    chk("wr_dg0", 32'(m0_data_gnt), 32'd0);
    chk("wr_rd0", m0_rdata, 32'd0);
    chk("wr_sreq", 32'(s_req), 32'd0);
    nxt();
    s_data_gnt = 0;
    @(negedge clk);
    chk_idle_outs("wr_end");
    nxt();

    // Stray s_data_gnt in IDLE is ignored and the FSM stays idle
    s_data_gnt = 1; s_rdata = 32'h7777_7777;
    @(negedge clk);
    chk_idle_outs("stray");
    nxt();
    s_data_gnt = 0; m0_req = 1; m0_addr = 32'h300;
    @(negedge clk);
    chk("stray_g0", 32'(m0_gnt), 32'd1);
    nxt();

    // Reset while waiting for the response drops the transaction
    m0_req = 0; s_gnt = 1;
    @(negedge clk);
    chk("ar_sreq", 32'(s_req), 32'd1);
    chk("ar_saddr", s_addr, 32'h300);
    nxt();
    s_gnt = 0; m1_req = 1; m1_addr = 32'h44;
    #1 arst = 1;
    @(negedge clk);
    chk_idle_outs("ar_in");
    chk("ar_in_g1", 32'(m1_gnt), 32'd0);
    nxt();
    arst = 0; s_data_gnt = 1; s_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("ar_late_g1", 32'(m1_gnt), 32'd1);
    chk("ar_late_dg0", 32'(m0_data_gnt), 32'd0);
    chk("ar_late_dg1", 32'(m1_data_gnt), 32'd0);
    nxt();
    s_data_gnt = 0; s_gnt = 1; m1_req = 0;
    @(negedge clk);
    chk("ar_m1_sreq", 32'(s_req), 32'd1);
    chk("ar_m1_saddr", s_addr, 32'h44);
    nxt();
    s_gnt = 0; s_data_gnt = 1; s_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("ar_m1_dg1", 32'(m1_data_gnt), 32'd1);
    chk("ar_m1_rd1", m1_rdata, 32'hCAFE_F00D);
    chk("ar_m1_dg0", 32'(m0_data_gnt), 32'd0);
    nxt();
    s_data_gnt = 0;
    @(negedge clk);
    chk_idle_outs("ar_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ladybird_bus_arbiter.md
LADYBIRD_BUS_ARBITER -- requirements
Module: ladybird_bus_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default ladybird_config::XLEN (32), data and address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports m0_req/m1_req  input  1  requester 0 (instruction fetch) and requester 1 (data) transaction requests.
REQ-005 SHALL have ports m0_addr/m1_addr  input  XLEN  request byte address.
REQ-006 SHALL have ports m0_wdata/m1_wdata  input  XLEN  store data.
REQ-007 SHALL have ports m0_wstrb/m1_wstrb  input  XLEN/8  byte write strobes; all-zero means read.
REQ-008 SHALL have ports m0_gnt/m1_gnt  output  1  request accepted (captured) this cycle.
REQ-009 SHALL have ports m0_data_gnt/m1_data_gnt  output  1  one-cycle response valid to the owning requester.
REQ-010 SHALL have ports m0_rdata/m1_rdata  output  XLEN  response data, valid while the matching data_gnt is high.
REQ-011 SHALL have ports s_req  output  1, s_addr  output  XLEN, s_wdata  output  XLEN, s_wstrb  output  XLEN/8  shared memory port request.
REQ-012 SHALL have ports s_gnt  input  1  (memory accepted request) and s_data_gnt  input  1, s_rdata  input  XLEN  (memory response).

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT_RSP; at most one transaction outstanding on the shared port.
REQ-014 In IDLE, if any m*_req is high, SHALL select one owner, assert that m*_gnt combinationally in the same cycle, latch addr/wdata/wstrb and owner, and go to ISSUE.
REQ-015 With both requests high in IDLE, SHALL grant the requester not served last (round-robin); after reset, requester 0 has priority.
REQ-016 m*_gnt SHALL be high only in IDLE, for at most one requester, never both.
REQ-017 In ISSUE, s_req SHALL be high with latched fields; on s_gnt high, go to WAIT_RSP; latched fields SHALL be stable until s_gnt.
REQ-018 In WAIT_RSP, on s_data_gnt high, SHALL drive the owner's data_gnt high and m*_rdata = s_rdata in that same cycle, update last-served to owner, and return to IDLE.
REQ-019 Every request, read or write, SHALL receive exactly one data_gnt pulse.
REQ-020 s_data_gnt outside WAIT_RSP SHALL be ignored; no data_gnt output SHALL pulse.
REQ-021 Non-owner data_gnt SHALL stay low; m*_rdata of non-owner SHALL be 0.
REQ-022 Minimum round trip: gnt cycle N, s_req from N+1, data_gnt at N+2 if s_gnt at N+1 and s_data_gnt at N+2; a new grant SHALL be possible no earlier than the cycle after data_gnt.
REQ-023 s_addr/s_wdata/s_wstrb SHALL be 0 and s_req low when not in ISSUE.

Reset
REQ-024 arst high SHALL force state IDLE, priority to requester 0, latched fields 0, all outputs low/0, asynchronously.
REQ-025 Reset during ISSUE or WAIT_RSP SHALL drop the transaction without any data_gnt; late s_data_gnt after release SHALL be ignored per REQ-020.

Structure
REQ-026 XLEN SHALL come from package ladybird_config; the arbiter state enum SHALL be local to the module.
REQ-027 No sub-module; single module with one registered FSM plus combinational output decode.

Verification
REQ-028 Only m0_req, addr 0x100, wstrb 0; memory gnt next cycle, s_rdata 0xDEADBEEF one cycle later -> m0_gnt cycle 0, s_req cycle 1, m0_data_gnt with 0xDEADBEEF cycle 2.
REQ-029 m0_req and m1_req held high continuously from reset -> grants alternate m0, m1, m0, m1; never both in one cycle.
REQ-030 m1 write addr 0x20, wdata 0x12345678, wstrb 0001, s_gnt delayed 3 cycles -> s_req held 4 cycles with stable fields, one m1_data_gnt after s_data_gnt.
REQ-031 s_data_gnt pulsed while IDLE -> no data_gnt on either requester, state stays IDLE.
REQ-032 arst asserted in WAIT_RSP, s_data_gnt arrives after release -> no data_gnt; next m1 request granted and completes normally.
